// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_unit_if;
    localparam int unsigned DW = 16;

    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
    modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage engine: runs loads/stores over the dm req/ack bus, stalls the
// front of the pipeline while an access is pending, and registers MEM/WB.
// Optional macro STORE_BUFFER_EN: one-entry posted store buffer.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [15:0]         in_pc,
    input  logic [15:0]         in_alu_out,
    input  logic [15:0]         in_dw_data,
    input  logic [15:0]         in_immedia,
    input  logic [3:0]          in_rfw_addr,
    input  logic [1:0]          in_wb_sel,
    input  logic                in_dm_wen,
    input  logic                in_dm_ren,
    input  logic                in_rfwen,
    mem_access_unit_if.master   dm,
    output logic                stall,
    output logic                wb_valid,
    output logic [15:0]         wb_data,
    output logic [3:0]          wb_addr,
    output logic                wb_en,
    output logic                bus_err
);
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           dm_req_q, dm_we_q;
    logic [DW-1:0]  dm_addr_q, dm_wdata_q;
    logic [DW-1:0]  op_pc_q, op_imm_q;
    logic [AW-1:0]  op_rfw_addr_q;
    logic [1:0]     op_sel_q;
    logic           op_rfwen_q;
    logic           wb_valid_q, wb_en_q, bus_err_q;
    logic [DW-1:0]  wb_data_q;
    logic [AW-1:0]  wb_addr_q;
    logic           mem_op_c, ack_c, tmo_c, sb_busy_c;
`ifdef STORE_BUFFER_EN
    logic           posted_q;
    assign sb_busy_c = posted_q;
`else
    assign sb_busy_c = 1'b0;
`endif

    assign mem_op_c = in_valid & (in_dm_wen | in_dm_ren);
    // An ack only counts while a request is outstanding.
    assign ack_c    = dm_req_q & dm.dm_ack;
    assign tmo_c    = dm_req_q & ~dm.dm_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_wdata = dm_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_addr     = wb_addr_q;
    assign wb_en       = wb_en_q;
    assign bus_err     = bus_err_q;

    function automatic logic [DW-1:0] wb_mux(input logic [1:0] sel, input logic [DW-1:0] alu,
                                             input logic [DW-1:0] mem, input logic [DW-1:0] pc,
                                             input logic [DW-1:0] imm);
        case (sel)
            2'd0:    wb_mux = alu;
            2'd1:    wb_mux = mem;
            2'd2:    wb_mux = pc;
            default: wb_mux = imm;
        endcase
    endfunction

    // Freeze the front end while a memory op waits; also released on timeout so
    // the aborted instruction retires instead of being re-issued.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            if (state_q == ST_WAIT) begin
                stall = ~(ack_c | tmo_c);
            end else if (mem_op_c) begin
`ifdef STORE_BUFFER_EN
                stall = posted_q | ~in_dm_wen;
`else
                stall = 1'b1;
`endif
            end
        end
    end

    // FSM, memory bus registers and MEM/WB bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dm_req_q      <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            op_pc_q       <= '0;
            op_imm_q      <= '0;
            op_rfw_addr_q <= '0;
            op_sel_q      <= '0;
            op_rfwen_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_en_q       <= 1'b0;
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            bus_err_q     <= 1'b0;
`ifdef STORE_BUFFER_EN
            posted_q      <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
`ifdef STORE_BUFFER_EN
                    // Posted store drains in the background.
                    if (posted_q) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (ack_c || tmo_c) begin
                            dm_req_q <= 1'b0;
                            dm_we_q  <= 1'b0;
                            posted_q <= 1'b0;
                            if (tmo_c) bus_err_q <= 1'b1;
                        end
                    end
`endif
                    if (in_valid && !mem_op_c) begin
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= in_rfwen;
                        wb_addr_q  <= in_rfw_addr;
                        wb_data_q  <= wb_mux(in_wb_sel, in_alu_out, in_alu_out, in_pc, in_immedia);
                    end else if (mem_op_c && !sb_busy_c) begin
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= in_dm_wen;
                        dm_addr_q  <= in_alu_out;
                        dm_wdata_q <= in_dw_data;
                        cnt_q      <= '0;
`ifdef STORE_BUFFER_EN
                        if (in_dm_wen) begin
                            posted_q   <= 1'b1;
                            wb_valid_q <= 1'b1;
                            wb_addr_q  <= in_rfw_addr;
                        end else begin
                            state_q <= ST_WAIT;
                        end
`else
                        state_q <= ST_WAIT;
`endif
                        op_pc_q       <= in_pc;
                        op_imm_q      <= in_immedia;
                        op_rfw_addr_q <= in_rfw_addr;
                        op_sel_q      <= in_wb_sel;
                        op_rfwen_q    <= in_rfwen;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (ack_c) begin
                        state_q    <= ST_IDLE;
                        dm_req_q   <= 1'b0;
                        dm_we_q    <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= op_rfwen_q & ~dm_we_q;
                        wb_addr_q  <= op_rfw_addr_q;
                        wb_data_q  <= wb_mux(op_sel_q, dm_addr_q, dm.dm_rdata, op_pc_q, op_imm_q);
                    end else if (tmo_c) begin
                        state_q    <= ST_IDLE;
                        dm_req_q   <= 1'b0;
                        dm_we_q    <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= op_rfw_addr_q;
                        bus_err_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_dm_wen, in_dm_ren, in_rfwen;
    logic [15:0] in_pc, in_alu_out, in_dw_data, in_immedia;
    logic [3:0]  in_rfw_addr;
    logic [1:0]  in_wb_sel;
    logic        stall, wb_valid, wb_en, bus_err;
    logic [15:0] wb_data;
    logic [3:0]  wb_addr;
    int          checks = 0;
    int          failures = 0;

    mem_access_unit_if dmi();

    mem_access_unit #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
        .in_dw_data(in_dw_data), .in_immedia(in_immedia), .in_rfw_addr(in_rfw_addr),
        .in_wb_sel(in_wb_sel), .in_dm_wen(in_dm_wen), .in_dm_ren(in_dm_ren), .in_rfwen(in_rfwen),
        .dm(dmi), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_en(wb_en), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        in_valid = 0; in_dm_wen = 0; in_dm_ren = 0; in_rfwen = 0;
        in_pc = 0; in_alu_out = 0; in_dw_data = 0; in_immedia = 0; in_rfw_addr = 0; in_wb_sel = 0;
    endtask

    task automatic op(input logic wen, input logic ren, input logic [15:0] alu, input logic [15:0] dw,
                      input logic [1:0] sel, input logic rfwen, input logic [3:0] ra);
        in_valid = 1; in_dm_wen = wen; in_dm_ren = ren; in_alu_out = alu; in_dw_data = dw;
        in_wb_sel = sel; in_rfwen = rfwen; in_rfw_addr = ra;
    endtask

    task automatic test_reset();
        rst = 0; bubble(); dmi.dm_ack = 0; dmi.dm_rdata = 0;
        #12;
        checks++; if (dmi.dm_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmi.dm_req); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wbv got=%b exp=0", wb_valid); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_err); end
        checks++; if (wb_data !== 16'h0) begin failures++; $display("FAIL reset_wbd got=%h exp=0000", wb_data); end
        #5 rst = 1;
        tick();
    endtask

    task automatic test_alu();
        op(0, 0, 16'h1234, 16'h0, 2'd0, 1, 4'd3);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wbv got=%b exp=1", wb_valid); end
        checks++; if (wb_data !== 16'h1234) begin failures++; $display("FAIL alu_wbd got=%h exp=1234", wb_data); end
        checks++; if (wb_addr !== 4'd3) begin failures++; $display("FAIL alu_wba got=%0d exp=3", wb_addr); end
        checks++; if (wb_en !== 1'b1) begin failures++; $display("FAIL alu_wbe got=%b exp=1", wb_en); end
        bubble();
        // Stray ack in IDLE with no request must be ignored.
        dmi.dm_ack = 1; dmi.dm_rdata = 16'hDEAD;
        tick();
        dmi.dm_ack = 0;
        checks++; if (wb_valid !== 1'b0 || wb_en !== 1'b0) begin failures++; $display("FAIL bubble_wb got=%b%b exp=00", wb_valid, wb_en); end
        checks++; if (wb_data !== 16'h1234 || wb_addr !== 4'd3) begin failures++; $display("FAIL bubble_hold got=%h/%0d exp=1234/3", wb_data, wb_addr); end
        checks++; if (dmi.dm_req !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL stray_ack got=%b%b exp=00", dmi.dm_req, bus_err); end
    endtask

    task automatic test_back_to_back();
        op(0, 0, 16'h0, 16'h0, 2'd2, 1, 4'd5); in_pc = 16'h0100;
        tick();
        checks++; if (wb_data !== 16'h0100 || wb_addr !== 4'd5 || wb_en !== 1'b1) begin failures++; $display("FAIL b2b_pc got=%h/%0d/%b exp=0100/5/1", wb_data, wb_addr, wb_en); end
        op(0, 0, 16'h0, 16'h0, 2'd3, 0, 4'd6); in_immedia = 16'hCAFE;
        tick();
        checks++; if (wb_data !== 16'hCAFE || wb_valid !== 1'b1 || wb_en !== 1'b0) begin failures++; $display("FAIL b2b_imm got=%h/%b/%b exp=cafe/1/0", wb_data, wb_valid, wb_en); end
        bubble();
        tick();
    endtask

    task automatic test_load();
        int n = 0;
        op(0, 1, 16'h0040, 16'h0, 2'd1, 1, 4'd7);
        #1;
        if (stall) n++;
        checks++; if (dmi.dm_req !== 1'b0) begin failures++; $display("FAIL load_req_early got=%b exp=0", dmi.dm_req); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall) n++;
            checks++; if (dmi.dm_req !== 1'b1 || dmi.dm_we !== 1'b0 || dmi.dm_addr !== 16'h0040) begin failures++; $display("FAIL load_bus got=%b%b/%h exp=10/0040", dmi.dm_req, dmi.dm_we, dmi.dm_addr); end
            tick();
        end
        dmi.dm_ack = 1; dmi.dm_rdata = 16'hBEEF;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_ack_stall got=%b exp=0", stall); end
        tick();
        dmi.dm_ack = 0; bubble();
        checks++; if (n != 4) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=4", n); end
        checks++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_en !== 1'b1 || wb_addr !== 4'd7) begin failures++; $display("FAIL load_wb got=%b/%h/%b/%0d exp=1/beef/1/7", wb_valid, wb_data, wb_en, wb_addr); end
        checks++; if (dmi.dm_req !== 1'b0) begin failures++; $display("FAIL load_req_drop got=%b exp=0", dmi.dm_req); end
        tick();
    endtask

    task automatic test_store();
        op(1, 0, 16'h0010, 16'h00A5, 2'd0, 1, 4'd2);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL store_stall got=%b exp=1", stall); end
        tick();
        checks++; if (dmi.dm_req !== 1'b1 || dmi.dm_we !== 1'b1 || dmi.dm_wdata !== 16'h00A5 || dmi.dm_addr !== 16'h0010) begin failures++; $display("FAIL store_bus got=%b%b/%h/%h exp=11/00a5/0010", dmi.dm_req, dmi.dm_we, dmi.dm_wdata, dmi.dm_addr); end
        dmi.dm_ack = 1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_ack_stall got=%b exp=0", stall); end
        tick();
        dmi.dm_ack = 0; bubble();
        checks++; if (wb_valid !== 1'b1 || wb_en !== 1'b0) begin failures++; $display("FAIL store_wb got=%b%b exp=10", wb_valid, wb_en); end
        checks++; if (dmi.dm_req !== 1'b0 || dmi.dm_we !== 1'b0) begin failures++; $display("FAIL store_drop got=%b%b exp=00", dmi.dm_req, dmi.dm_we); end
        tick();
    endtask

    task automatic test_ack_at_limit();
        op(0, 1, 16'h0050, 16'h0, 2'd1, 1, 4'd8);
        tick();
        for (int i = 0; i < 63; i++) tick();
        checks++; if (dmi.dm_req !== 1'b1) begin failures++; $display("FAIL limit_req got=%b exp=1", dmi.dm_req); end
        dmi.dm_ack = 1; dmi.dm_rdata = 16'h4242;
        tick();
        dmi.dm_ack = 0; bubble();
        checks++; if (wb_en !== 1'b1 || wb_data !== 16'h4242 || bus_err !== 1'b0) begin failures++; $display("FAIL limit_ack got=%b/%h/%b exp=1/4242/0", wb_en, wb_data, bus_err); end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        op(0, 1, 16'h0080, 16'h0, 2'd1, 1, 4'd9);
        tick();
        while (dmi.dm_req === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        bubble();
        checks++; if (n != 64) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=64", n); end
        checks++; if (wb_valid !== 1'b1 || wb_en !== 1'b0 || bus_err !== 1'b1) begin failures++; $display("FAIL tmo_wb got=%b%b err=%b exp=10 err=1", wb_valid, wb_en, bus_err); end
        op(0, 0, 16'h0007, 16'h0, 2'd0, 1, 4'd1);
        tick(); bubble(); tick(); tick();
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", bus_err); end
    endtask

    task automatic test_async_reset();
        op(0, 1, 16'h0060, 16'h0, 2'd1, 1, 4'd4);
        tick(); tick(); tick();
        #3 rst = 0;
        #1;
        checks++; if (dmi.dm_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL arst_drop got=%b%b%b%b exp=0000", dmi.dm_req, stall, wb_valid, bus_err); end
        bubble();
        tick();
        #2 rst = 1;
        tick();
        op(0, 0, 16'h5A5A, 16'h0, 2'd0, 1, 4'd9);
        tick();
        bubble();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h5A5A || wb_addr !== 4'd9 || wb_en !== 1'b1) begin failures++; $display("FAIL arst_alu got=%b/%h/%0d/%b exp=1/5a5a/9/1", wb_valid, wb_data, wb_addr, wb_en); end
        tick();
    endtask

`ifdef STORE_BUFFER_EN
    task automatic test_store_buffer();
        int n = 0;
        op(1, 0, 16'h0020, 16'h1111, 2'd0, 0, 4'd0);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_store_stall got=%b exp=0", stall); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_en !== 1'b0 || dmi.dm_req !== 1'b1 || dmi.dm_we !== 1'b1) begin failures++; $display("FAIL sb_post got=%b%b%b%b exp=1011", wb_valid, wb_en, dmi.dm_req, dmi.dm_we); end
        op(0, 0, 16'h0002, 16'h0, 2'd0, 1, 4'd2);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_alu_stall got=%b exp=0", stall); end
        tick();
        checks++; if (wb_data !== 16'h0002 || wb_en !== 1'b1) begin failures++; $display("FAIL sb_alu_wb got=%h/%b exp=0002/1", wb_data, wb_en); end
        op(0, 1, 16'h0030, 16'h0, 2'd1, 1, 4'd4);
        for (int i = 0; i < 3; i++) begin #1; if (stall) n++; tick(); end
        dmi.dm_ack = 1;
        #1; if (stall) n++;
        tick();
        dmi.dm_ack = 0;
        checks++; if (n != 4 || dmi.dm_req !== 1'b0) begin failures++; $display("FAIL sb_wait got=%0d/%b exp=4/0", n, dmi.dm_req); end
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_accept_stall got=%b exp=1", stall); end
        tick();
        checks++; if (dmi.dm_req !== 1'b1 || dmi.dm_we !== 1'b0 || dmi.dm_addr !== 16'h0030) begin failures++; $display("FAIL sb_load_bus got=%b%b/%h exp=10/0030", dmi.dm_req, dmi.dm_we, dmi.dm_addr); end
        dmi.dm_ack = 1; dmi.dm_rdata = 16'h7777;
        tick();
        dmi.dm_ack = 0; bubble();
        checks++; if (wb_data !== 16'h7777 || wb_en !== 1'b1 || wb_addr !== 4'd4) begin failures++; $display("FAIL sb_load_wb got=%h/%b/%0d exp=7777/1/4", wb_data, wb_en, wb_addr); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
`ifdef STORE_BUFFER_EN
        test_store_buffer();
`else
        test_store();
`endif
        test_ack_at_limit();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
